// File: rtl/reg_file_banked_if.sv
// rtl/reg_file_banked_if.sv - register-file control and read bus
// Control, select and read-back signals of the banked register file.
interface reg_file_banked_if #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3
);
   logic [1:0]          FunSel;
   logic [NUM_REGS-1:0] RegSel;
   logic [WIDTH-1:0]    I;
   logic                Swap;
   logic [SEL_W-1:0]    O1Sel;
   logic [SEL_W-1:0]    O2Sel;
   logic [WIDTH-1:0]    O1;
   logic [WIDTH-1:0]    O2;
   logic [NUM_REGS-1:0] Zero;
   logic                Ovf;

   modport master (
      output FunSel, RegSel, I, Swap, O1Sel, O2Sel,
      input  O1, O2, Zero, Ovf
   );

   modport slave (
      input  FunSel, RegSel, I, Swap, O1Sel, O2Sel,
      output O1, O2, Zero, Ovf
   );
endinterface

// File: rtl/reg_file_banked.sv
// rtl/reg_file_banked.sv - parametrised register file with shadow bank swap
// Live bank feeds two combinational read ports; a swap exchanges live and shadow in one edge.
module reg_file_banked #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3,
   parameter bit SATURATE = 1'b0
) (
   input  logic            CLK,
   input  logic            Reset_n,
   reg_file_banked_if.slave bus
);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0]    live_q [NUM_REGS];
   logic [WIDTH-1:0]    live_d [NUM_REGS];
   logic [WIDTH-1:0]    shad_q [NUM_REGS];
   logic [WIDTH-1:0]    shad_d [NUM_REGS];
   logic                ovf_q;
   logic                ovf_d;
   logic [WIDTH-1:0]    o1;
   logic [WIDTH-1:0]    o2;
   logic [NUM_REGS-1:0] zero;

   always_comb begin
      live_d = live_q;
      shad_d = shad_q;
      ovf_d  = 1'b0;
      if (bus.Swap) begin
         // Swap wins outright: the write controls are dropped, and Ovf clears.
         live_d = shad_q;
         shad_d = live_q;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.RegSel[k]) begin
               case (bus.FunSel)
                  2'b10: live_d[k] = bus.I;
                  2'b11: live_d[k] = '0;
                  2'b01: begin
                     if (live_q[k] == ALL_ONES) begin
                        ovf_d     = 1'b1;
                        live_d[k] = SATURATE ? ALL_ONES : '0;
                     end else begin
                        live_d[k] = live_q[k] + ONE;
                     end
                  end
                  default: begin
                     if (live_q[k] == '0) begin
                        ovf_d     = 1'b1;
                        live_d[k] = SATURATE ? '0 : ALL_ONES;
                     end else begin
                        live_d[k] = live_q[k] - ONE;
                     end
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            live_q[k] <= '0;
            shad_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else begin
         live_q <= live_d;
         shad_q <= shad_d;
         ovf_q  <= ovf_d;
      end
   end

   // Selects beyond NUM_REGS match no register and so read as zero.
   always_comb begin
      o1   = '0;
      o2   = '0;
      zero = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (bus.O1Sel == SEL_W'(k)) o1 = live_q[k];
         if (bus.O2Sel == SEL_W'(k)) o2 = live_q[k];
         zero[k] = (live_q[k] == '0);
      end
   end

   assign bus.O1   = o1;
   assign bus.O2   = o2;
   assign bus.Zero = zero;
   assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_reg_file_banked.sv
// tb/tb_reg_file_banked.sv - bench for reg_file_banked
// Wrap, saturate and six-register instances share stimulus; a bank-array model predicts results.
module tb_reg_file_banked;
   logic       CLK;
   logic       Reset_n;
   logic [1:0] fun_sel;
   logic [7:0] reg_sel;
   logic [7:0] i_data;
   logic       swap;
   logic [2:0] o1_sel;
   logic [2:0] o2_sel;

   int checks   = 0;
   int failures = 0;

   // model: index 0 = wrapping bank pair, 1 = saturating bank pair
   logic [7:0] mlive [2][8];
   logic [7:0] mshad [2][8];
   logic       movf  [2];

   reg_file_banked_if #(.WIDTH(8), .NUM_REGS(8), .SEL_W(3)) bw ();
   reg_file_banked_if #(.WIDTH(8), .NUM_REGS(8), .SEL_W(3)) bs ();
   reg_file_banked_if #(.WIDTH(8), .NUM_REGS(6), .SEL_W(3)) bn ();

   assign bw.FunSel = fun_sel;  assign bs.FunSel = fun_sel;  assign bn.FunSel = fun_sel;
   assign bw.RegSel = reg_sel;  assign bs.RegSel = reg_sel;  assign bn.RegSel = reg_sel[5:0];
   assign bw.I      = i_data;   assign bs.I      = i_data;   assign bn.I      = i_data;
   assign bw.Swap   = swap;     assign bs.Swap   = swap;     assign bn.Swap   = swap;
   assign bw.O1Sel  = o1_sel;   assign bs.O1Sel  = o1_sel;   assign bn.O1Sel  = o1_sel;
   assign bw.O2Sel  = o2_sel;   assign bs.O2Sel  = o2_sel;   assign bn.O2Sel  = o2_sel;

   reg_file_banked #(.WIDTH(8), .NUM_REGS(8), .SEL_W(3), .SATURATE(1'b0)) dut_w (
      .CLK(CLK), .Reset_n(Reset_n), .bus(bw.slave));
   reg_file_banked #(.WIDTH(8), .NUM_REGS(8), .SEL_W(3), .SATURATE(1'b1)) dut_s (
      .CLK(CLK), .Reset_n(Reset_n), .bus(bs.slave));
   reg_file_banked #(.WIDTH(8), .NUM_REGS(6), .SEL_W(3), .SATURATE(1'b0)) dut_n (
      .CLK(CLK), .Reset_n(Reset_n), .bus(bn.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] mzero(int d);
      logic [7:0] z;
      for (int k = 0; k < 8; k++) z[k] = (mlive[d][k] == 8'h00);
      return z;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) begin
            mlive[d][k] = 8'h00;
            mshad[d][k] = 8'h00;
         end
         movf[d] = 1'b0;
      end
   endtask

   // Predict the effect of the coming edge, then take it.
   task automatic do_edge();
      logic [7:0] t;
      for (int d = 0; d < 2; d++) begin
         movf[d] = 1'b0;
         if (swap) begin
            for (int k = 0; k < 8; k++) begin
               t = mlive[d][k];
               mlive[d][k] = mshad[d][k];
               mshad[d][k] = t;
            end
         end else begin
            for (int k = 0; k < 8; k++) begin
               if (reg_sel[k]) begin
                  case (fun_sel)
                     2'd2: mlive[d][k] = i_data;
                     2'd3: mlive[d][k] = 8'h00;
                     2'd1: begin
                        if (mlive[d][k] == 8'd255) begin
                           movf[d] = 1'b1;
                           mlive[d][k] = (d == 0) ? 8'd0 : 8'd255;
                        end else mlive[d][k] = mlive[d][k] + 8'd1;
                     end
                     default: begin
                        if (mlive[d][k] == 8'd0) begin
                           movf[d] = 1'b1;
                           mlive[d][k] = (d == 0) ? 8'd255 : 8'd0;
                        end else mlive[d][k] = mlive[d][k] - 8'd1;
                     end
                  endcase
               end
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      Reset_n = 1'b1;
      o1_sel = 3'd0; o2_sel = 3'd7;
      #1;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL reset_o1 got=%h exp=00", bw.O1); end
      checks++; if (bw.O2 !== 8'h00) begin failures++; $display("FAIL reset_o2 got=%h exp=00", bw.O2); end
      checks++; if (bw.Zero !== 8'hFF) begin failures++; $display("FAIL reset_zero got=%h exp=ff", bw.Zero); end
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bw.Ovf); end
      checks++; if (bn.Zero !== 6'h3F) begin failures++; $display("FAIL reset_zero_n got=%h exp=3f", bn.Zero); end
      do_edge();
   endtask

   task automatic test_load();
      o1_sel = 3'd0; reg_sel = 8'b0000_0101; fun_sel = 2'd2; i_data = 8'hAA;
      #1;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL load_pre_edge got=%h exp=00", bw.O1); end
      do_edge();
      reg_sel = 8'h00;
      checks++; if (bw.O1 !== 8'hAA) begin failures++; $display("FAIL load_r0 got=%h exp=aa", bw.O1); end
      o1_sel = 3'd2; o2_sel = 3'd1;
      #1;
      checks++; if (bw.O1 !== 8'hAA) begin failures++; $display("FAIL load_r2 got=%h exp=aa", bw.O1); end
      checks++; if (bw.O2 !== 8'h00) begin failures++; $display("FAIL load_r1 got=%h exp=00", bw.O2); end
      checks++; if (bw.Zero !== 8'b1111_1010) begin failures++; $display("FAIL load_zero got=%h exp=fa", bw.Zero); end
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL load_ovf got=%b exp=0", bw.Ovf); end
   endtask

   task automatic test_inc_wrap();
      reg_sel = 8'h08; fun_sel = 2'd2; i_data = 8'hFF;
      do_edge();
      fun_sel = 2'd1;
      do_edge();
      reg_sel = 8'h00; o1_sel = 3'd3;
      #1;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL inc_wrap_val got=%h exp=00", bw.O1); end
      checks++; if (bs.O1 !== 8'hFF) begin failures++; $display("FAIL inc_sat_val got=%h exp=ff", bs.O1); end
      checks++; if (bw.Zero[3] !== 1'b1) begin failures++; $display("FAIL inc_wrap_zero got=%b exp=1", bw.Zero[3]); end
      checks++; if (bw.Ovf !== 1'b1) begin failures++; $display("FAIL inc_wrap_ovf got=%b exp=1", bw.Ovf); end
      checks++; if (bs.Ovf !== 1'b1) begin failures++; $display("FAIL inc_sat_ovf got=%b exp=1", bs.Ovf); end
      do_edge();
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL inc_ovf_drop_w got=%b exp=0", bw.Ovf); end
      checks++; if (bs.Ovf !== 1'b0) begin failures++; $display("FAIL inc_ovf_drop_s got=%b exp=0", bs.Ovf); end
   endtask

   task automatic test_dec();
      reg_sel = 8'h20; fun_sel = 2'd3;
      do_edge();
      fun_sel = 2'd0;
      do_edge();
      reg_sel = 8'h00; o1_sel = 3'd5;
      #1;
      checks++; if (bw.O1 !== 8'hFF) begin failures++; $display("FAIL dec_wrap_val got=%h exp=ff", bw.O1); end
      checks++; if (bs.O1 !== 8'h00) begin failures++; $display("FAIL dec_sat_val got=%h exp=00", bs.O1); end
      checks++; if (bw.Ovf !== 1'b1) begin failures++; $display("FAIL dec_wrap_ovf got=%b exp=1", bw.Ovf); end
      checks++; if (bs.Ovf !== 1'b1) begin failures++; $display("FAIL dec_sat_ovf got=%b exp=1", bs.Ovf); end
      reg_sel = 8'h20; fun_sel = 2'd2; i_data = 8'h01;
      do_edge();
      fun_sel = 2'd0;
      do_edge();
      reg_sel = 8'h00;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL dec_one_val got=%h exp=00", bw.O1); end
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL dec_one_ovf got=%b exp=0", bw.Ovf); end
      checks++; if (bs.Ovf !== 1'b0) begin failures++; $display("FAIL dec_one_ovf_s got=%b exp=0", bs.Ovf); end
   endtask

   task automatic test_swap();
      o1_sel = 3'd0;
      reg_sel = 8'h01; fun_sel = 2'd2; i_data = 8'h11;
      do_edge();
      reg_sel = 8'h00; swap = 1'b1;
      do_edge();
      swap = 1'b0;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL swap_first got=%h exp=00", bw.O1); end
      reg_sel = 8'h01; i_data = 8'h22;
      do_edge();
      reg_sel = 8'h00;
      checks++; if (bw.O1 !== 8'h22) begin failures++; $display("FAIL swap_load got=%h exp=22", bw.O1); end
      swap = 1'b1;
      do_edge();
      swap = 1'b0;
      checks++; if (bw.O1 !== 8'h11) begin failures++; $display("FAIL swap_back got=%h exp=11", bw.O1); end
      checks++; if (bs.O1 !== 8'h11) begin failures++; $display("FAIL swap_back_s got=%h exp=11", bs.O1); end
   endtask

   task automatic test_swap_priority();
      o1_sel = 3'd0;
      swap = 1'b1; fun_sel = 2'd3; reg_sel = 8'hFF;
      do_edge();
      checks++; if (bw.O1 !== 8'h22) begin failures++; $display("FAIL swap_prio_r0 got=%h exp=22", bw.O1); end
      checks++; if (bw.Zero !== mzero(0)) begin failures++; $display("FAIL swap_prio_zero got=%h exp=%h", bw.Zero, mzero(0)); end
      fun_sel = 2'd0;
      do_edge();
      swap = 1'b0; reg_sel = 8'h00;
      checks++; if (bw.O1 !== 8'h11) begin failures++; $display("FAIL swap_prio_back got=%h exp=11", bw.O1); end
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL swap_ovf_w got=%b exp=0", bw.Ovf); end
      checks++; if (bs.Ovf !== 1'b0) begin failures++; $display("FAIL swap_ovf_s got=%b exp=0", bs.Ovf); end
      checks++; if (bs.Zero !== mzero(1)) begin failures++; $display("FAIL swap_prio_zero_s got=%h exp=%h", bs.Zero, mzero(1)); end
   endtask

   task automatic test_out_of_range();
      reg_sel = 8'hFF; fun_sel = 2'd2; i_data = 8'hC3;
      do_edge();
      reg_sel = 8'h00; o1_sel = 3'd6; o2_sel = 3'd7;
      #1;
      checks++; if (bn.O1 !== 8'h00) begin failures++; $display("FAIL oor_sel6 got=%h exp=00", bn.O1); end
      checks++; if (bn.O2 !== 8'h00) begin failures++; $display("FAIL oor_sel7 got=%h exp=00", bn.O2); end
      checks++; if (bw.O1 !== 8'hC3) begin failures++; $display("FAIL inrange_sel6 got=%h exp=c3", bw.O1); end
      o1_sel = 3'd5;
      #1;
      checks++; if (bn.O1 !== 8'hC3) begin failures++; $display("FAIL last_reg_n got=%h exp=c3", bn.O1); end
   endtask

   task automatic test_random();
      logic [7:0] e1;
      for (int n = 0; n < 400; n++) begin
         swap    = ($urandom_range(0, 5) == 0);
         fun_sel = 2'($urandom_range(0, 3));
         reg_sel = 8'($urandom);
         case ($urandom_range(0, 3))
            0: i_data = 8'h00;
            1: i_data = 8'hFF;
            default: i_data = 8'($urandom);
         endcase
         do_edge();
         o1_sel = 3'($urandom_range(0, 7));
         o2_sel = 3'($urandom_range(0, 7));
         #1;
         checks++; if (bw.O1 !== mlive[0][o1_sel]) begin failures++; $display("FAIL rnd_o1_w n=%0d got=%h exp=%h", n, bw.O1, mlive[0][o1_sel]); end
         checks++; if (bs.O2 !== mlive[1][o2_sel]) begin failures++; $display("FAIL rnd_o2_s n=%0d got=%h exp=%h", n, bs.O2, mlive[1][o2_sel]); end
         checks++; if (bw.Zero !== mzero(0)) begin failures++; $display("FAIL rnd_zero_w n=%0d got=%h exp=%h", n, bw.Zero, mzero(0)); end
         checks++; if (bs.Zero !== mzero(1)) begin failures++; $display("FAIL rnd_zero_s n=%0d got=%h exp=%h", n, bs.Zero, mzero(1)); end
         checks++; if (bw.Ovf !== movf[0]) begin failures++; $display("FAIL rnd_ovf_w n=%0d got=%b exp=%b", n, bw.Ovf, movf[0]); end
         checks++; if (bs.Ovf !== movf[1]) begin failures++; $display("FAIL rnd_ovf_s n=%0d got=%b exp=%b", n, bs.Ovf, movf[1]); end
         e1 = (o1_sel < 3'd6) ? mlive[0][o1_sel] : 8'h00;
         checks++; if (bn.O1 !== e1) begin failures++; $display("FAIL rnd_o1_n n=%0d got=%h exp=%h", n, bn.O1, e1); end
      end
      swap = 1'b0; reg_sel = 8'h00;
   endtask

   task automatic test_async_reset();
      o1_sel = 3'd1;
      reg_sel = 8'h02; fun_sel = 2'd2; i_data = 8'h5A;
      do_edge();
      reg_sel = 8'h00; swap = 1'b1;
      do_edge();
      swap = 1'b0; reg_sel = 8'h02;
      do_edge();
      reg_sel = 8'h00;
      checks++; if (bw.O1 !== 8'h5A) begin failures++; $display("FAIL areset_pre got=%h exp=5a", bw.O1); end
      #2;
      Reset_n = 1'b0;
      model_reset();
      #1;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL areset_live_w got=%h exp=00", bw.O1); end
      checks++; if (bs.O1 !== 8'h00) begin failures++; $display("FAIL areset_live_s got=%h exp=00", bs.O1); end
      checks++; if (bw.Zero !== 8'hFF) begin failures++; $display("FAIL areset_zero got=%h exp=ff", bw.Zero); end
      checks++; if (bw.Ovf !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b exp=0", bw.Ovf); end
      @(negedge CLK);
      Reset_n = 1'b1;
      swap = 1'b1;
      do_edge();
      swap = 1'b0;
      checks++; if (bw.O1 !== 8'h00) begin failures++; $display("FAIL areset_shadow got=%h exp=00", bw.O1); end
      checks++; if (bw.Zero !== 8'hFF) begin failures++; $display("FAIL areset_shadow_zero got=%h exp=ff", bw.Zero); end
   endtask

   initial begin
      Reset_n = 1'b0;
      fun_sel = 2'd0; reg_sel = 8'h00; i_data = 8'h00; swap = 1'b0;
      o1_sel = 3'd0; o2_sel = 3'd0;
      test_reset();
      test_load();
      test_inc_wrap();
      test_dec();
      test_swap();
      test_swap_priority();
      test_out_of_range();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_file_banked.md
Name: reg_file_banked

Overview:
- Parametrised successor to the fixed 8-bit register file. Generalised in register count and width.
- Adds a one-cycle shadow-bank swap for context save/restore.
- Selectable wrap or saturate arithmetic on increment/decrement, per-register zero flags, and a registered overflow pulse.
- Sits in the ALU system in place of the general-purpose register file. Feeds MuxA/MuxB/ALU through two combinational read ports.

Parameters:
- WIDTH, 8, data width of every register.
- NUM_REGS, 8, number of live registers; identical count in the shadow bank; range 2..16.
- SEL_W, 3, read-select width; must satisfy 2**SEL_W >= NUM_REGS.
- SATURATE, 0, 0 = increment/decrement wrap modulo 2**WIDTH; 1 = clamp at all-ones / zero.

Ports:
- CLK  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- FunSel  input  2  00 decrement, 01 increment, 10 load I, 11 clear
- RegSel  input  NUM_REGS  one bit per live register, 1 = apply FunSel at next edge; all-zero = hold
- I  input  WIDTH  load data
- Swap  input  1  exchange live and shadow banks at next edge
- O1Sel  input  SEL_W  read port 1 select
- O2Sel  input  SEL_W  read port 2 select
- O1  output  WIDTH  live register[O1Sel], combinational
- O2  output  WIDTH  live register[O2Sel], combinational
- Zero  output  NUM_REGS  bit k = 1 when live register k == 0, combinational from state
- Ovf  output  1  registered pulse: wrap/saturation occurred on previous edge

Behaviour:
- Reset (Reset_n low, asynchronous, any time including mid-swap): all live and shadow registers = 0, Ovf = 0. Consequently O1 = O2 = 0 and Zero = all ones. Reset dominates every other input.
- Read ports: pure mux of the current live state. No write-through bypass; a write is visible on O1/O2 only after the edge.
- Out-of-range select (>= NUM_REGS): drives 0.
- Per rising edge with Swap = 0, for every k with RegSel[k] = 1:
  - 10: R[k] <= I.
  - 11: R[k] <= 0.
  - 01: R[k] <= R[k] + 1.
    - SATURATE = 0: all-ones wraps to 0.
    - SATURATE = 1: all-ones holds.
  - 00: R[k] <= R[k] - 1.
    - SATURATE = 0: 0 wraps to all-ones.
    - SATURATE = 1: 0 holds.
- Registers with RegSel[k] = 0 hold. The shadow bank holds.
- Multiple RegSel bits set apply the same operation independently to each selected register, using that register's own old value.
- Swap = 1 at an edge:
  - Live[k] <= Shadow[k] and Shadow[k] <= Live[k] for all k, simultaneously.
  - FunSel/RegSel are ignored that cycle; Swap has priority and no write is lost silently into either bank.
  - Ovf <= 0 on a swap cycle.
- Ovf:
  - Set to 1 for exactly one cycle after an edge where any selected register wrapped (SATURATE = 0) or was clamped (SATURATE = 1) on increment/decrement.
  - 0 after every other edge. Load and clear never set Ovf.
- Back-to-back Swap on consecutive edges restores the original banks.
- Zero updates combinationally from the new state right after each edge.

Test Plan:
- Reset then release: O1Sel = 0, O2Sel = 7 -> O1 = O2 = 0x00, Zero = 8'hFF, Ovf = 0.
- Load: RegSel = 8'b0000_0101, FunSel = 10, I = 0xAA, one edge.
  - O1Sel = 0 -> 0xAA; O1Sel = 2 -> 0xAA; O2Sel = 1 -> 0x00.
  - Zero = 8'b1111_1010.
  - O1 still shows the old value before the edge.
- Increment wrap, SATURATE = 0: R3 = 0xFF, increment -> R3 = 0x00, Zero[3] = 1, Ovf = 1 for one cycle then 0.
  - Same stimulus with SATURATE = 1 -> R3 stays 0xFF, Ovf = 1.
- Decrement from 0, SATURATE = 0: R5 = 0, decrement -> R5 = 0xFF, Ovf pulse.
  - Decrement R5 = 0x01 -> 0x00, Ovf = 0.
- Swap:
  - Sequence: R0 = 0x11, Swap -> O1(R0) = 0x00. Load R0 = 0x22 -> 0x22. Swap -> 0x11.
  - Swap asserted together with FunSel = 11, RegSel = all ones -> clear ignored, banks exchanged only.
- Async reset mid-stream: assert Reset_n low between edges after loading 0x5A into R1 and swapping -> both banks 0 immediately, without a clock edge. Ovf = 0.
